// File: rtl/btb_update_sched.sv
// rtl/btb_update_sched.sv - BTB write-port scheduler: update queue, entry update rules, invalidate sweep
// Owns the single BTB write port; the queue head drives a combinational BTB read.
module btb_update_sched #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 3,
  parameter int TAG_W = 3,
  parameter int TGT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       memory_stall,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [31:0]                upd_pc,
  input  logic                       upd_taken,
  input  logic [31:0]                upd_target,
  input  logic                       inv_req,
  output logic                       inv_busy,
  output logic                       lookup_block,
  output logic [IDX_W-1:0]           btb_rd_idx,
  input  logic [TAG_W+TGT_W+2:0]     btb_rd_entry,
  output logic                       btb_wr_en,
  output logic [IDX_W-1:0]           btb_wr_idx,
  output logic [TAG_W+TGT_W+2:0]     btb_wr_entry,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 1 + TAG_W + TGT_W + 2;

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_sweep_cnt;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W:0]     r_count;

  logic [IDX_W-1:0]   r_q_idx [DEPTH];
  logic [TAG_W-1:0]   r_q_tag [DEPTH];
  logic               r_q_taken [DEPTH];
  logic [TGT_W-1:0]   r_q_tgt [DEPTH];

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  logic               w_sweep_adv;
  logic               w_sweep_last;

  logic [IDX_W-1:0]   w_h_idx;
  logic [TAG_W-1:0]   w_h_tag;
  logic               w_h_taken;
  logic [TGT_W-1:0]   w_h_tgt;

  logic               w_rd_valid;
  logic [TAG_W-1:0]   w_rd_tag;
  logic [TGT_W-1:0]   w_rd_tgt;
  logic [1:0]         w_rd_hist;
  logic               w_hit;
  logic [1:0]         w_hist_nxt;
  logic               w_unused_bits;

  assign w_unused_bits = ^{upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0], upd_target[31:TGT_W]};

  assign w_full       = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign upd_ready    = !w_full && (r_state == ST_IDLE) && !inv_req;
  assign w_push       = upd_valid && upd_ready;
  assign inv_busy     = (r_state == ST_SWEEP);
  assign lookup_block = inv_busy;
  assign q_count      = r_count;
  assign w_sweep_last = (r_sweep_cnt == {IDX_W{1'b1}});

  assign w_h_idx   = r_q_idx[r_rd_ptr];
  assign w_h_tag   = r_q_tag[r_rd_ptr];
  assign w_h_taken = r_q_taken[r_rd_ptr];
  assign w_h_tgt   = r_q_tgt[r_rd_ptr];
  assign btb_rd_idx = w_h_idx;

  assign w_rd_valid = btb_rd_entry[ENT_W-1];
  assign w_rd_tag   = btb_rd_entry[ENT_W-2 -: TAG_W];
  assign w_rd_tgt   = btb_rd_entry[TGT_W+1:2];
  assign w_rd_hist  = btb_rd_entry[1:0];
  assign w_hit      = w_rd_valid && (w_rd_tag == w_h_tag);

  // Saturating 2-bit direction history step
  always_comb begin
    w_hist_nxt = w_rd_hist;
    if (w_h_taken) begin
      if (w_rd_hist != 2'b11) w_hist_nxt = w_rd_hist + 2'd1;
    end else begin
      if (w_rd_hist != 2'b00) w_hist_nxt = w_rd_hist - 2'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_flush      = 1'b0;
    w_pop        = 1'b0;
    w_sweep_adv  = 1'b0;
    btb_wr_en    = 1'b0;
    btb_wr_idx   = w_h_idx;
    btb_wr_entry = '0;
    case (r_state)
      ST_IDLE: begin
        if (inv_req) begin
          w_state_nxt = ST_SWEEP;
          w_flush     = 1'b1;
        end else if (!w_empty && !memory_stall) begin
          w_pop = 1'b1;
          if (!w_hit) begin
            btb_wr_en    = w_h_taken;
            btb_wr_entry = {1'b1, w_h_tag, w_h_tgt, 2'b10};
          end else if (w_h_taken && (w_rd_tgt != w_h_tgt)) begin
            btb_wr_en    = 1'b1;
            btb_wr_entry = {1'b1, w_h_tag, w_h_tgt, 2'b10};
          end else begin
            btb_wr_en    = 1'b1;
            btb_wr_entry = {1'b1, w_h_tag, w_rd_tgt, w_hist_nxt};
          end
        end
      end
      ST_SWEEP: begin
        btb_wr_idx = r_sweep_cnt;
        if (!memory_stall) begin
          btb_wr_en   = 1'b1;
          w_sweep_adv = 1'b1;
          if (w_sweep_last) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sweep_cnt <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_flush) begin
        r_sweep_cnt <= '0;
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
        r_count     <= '0;
      end else begin
        if (w_sweep_adv) r_sweep_cnt <= r_sweep_cnt + 1'b1;
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
      end
    end
  end

  // Queue payload needs no reset; occupancy alone decides what is live
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_idx[r_wr_ptr]   <= upd_pc[IDX_W+1:2];
      r_q_tag[r_wr_ptr]   <= upd_pc[IDX_W+TAG_W+1:IDX_W+2];
      r_q_taken[r_wr_ptr] <= upd_taken;
      r_q_tgt[r_wr_ptr]   <= upd_target[TGT_W-1:0];
    end
  end

endmodule

// File: tb/tb_btb_update_sched.sv
// tb/tb_btb_update_sched.sv - randomized bench for btb_update_sched against a queue/array reference model
module tb_btb_update_sched;

  localparam int DEPTH = 4;
  localparam int IDX_W = 3;
  localparam int TAG_W = 3;
  localparam int TGT_W = 8;
  localparam int ENT_W = 14;

  logic              clk;
  logic              rst;
  logic              memory_stall;
  logic              upd_valid;
  logic              upd_ready;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              inv_req;
  logic              inv_busy;
  logic              lookup_block;
  logic [2:0]        btb_rd_idx;
  logic [ENT_W-1:0]  btb_rd_entry;
  logic              btb_wr_en;
  logic [2:0]        btb_wr_idx;
  logic [ENT_W-1:0]  btb_wr_entry;
  logic [2:0]        q_count;

  btb_update_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W), .TGT_W(TGT_W)) dut (
    .clk(clk), .rst(rst), .memory_stall(memory_stall),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .inv_req(inv_req), .inv_busy(inv_busy), .lookup_block(lookup_block),
    .btb_rd_idx(btb_rd_idx), .btb_rd_entry(btb_rd_entry),
    .btb_wr_en(btb_wr_en), .btb_wr_idx(btb_wr_idx), .btb_wr_entry(btb_wr_entry),
    .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BTB storage seen by the DUT
  logic [ENT_W-1:0] mem [8];
  assign btb_rd_entry = mem[btb_rd_idx];
  always @(posedge clk) if (btb_wr_en) mem[btb_wr_idx] <= btb_wr_entry;

  typedef struct {
    logic [2:0] idx;
    logic [2:0] tag;
    logic       taken;
    logic [7:0] tgt;
  } upd_t;

  upd_t             mq[$];
  logic [ENT_W-1:0] ref_btb [8];
  bit               m_sweep;
  int               m_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic             o_rdy, o_busy, o_wr_en;
  logic [2:0]       o_cnt, o_wr_idx;
  logic [ENT_W-1:0] o_wr_ent;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                      input bit inv, input bit st, input bit rs);
    bit               e_rdy, e_wr, hit;
    logic [2:0]       e_idx;
    logic [ENT_W-1:0] e_ent, cur;
    int               h;
    upd_t             hd, nu;
    @(negedge clk);
    upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tg;
    inv_req = inv; memory_stall = st; rst = rs;
    #1;
    e_rdy = !m_sweep && (mq.size() < DEPTH) && !inv;
    e_wr = 0; e_idx = 0; e_ent = '0;
    if (m_sweep) begin
      if (!st) begin e_wr = 1; e_idx = 3'(m_cnt); end
    end else if (!inv && mq.size() > 0 && !st) begin
      hd = mq[0];
      cur = ref_btb[hd.idx];
      hit = cur[13] && (cur[12:10] == hd.tag);
      e_idx = hd.idx;
      if (!hit) begin
        e_wr = hd.taken;
        e_ent = {1'b1, hd.tag, hd.tgt, 2'b10};
      end else if (hd.taken && cur[9:2] != hd.tgt) begin
        e_wr = 1;
        e_ent = {1'b1, hd.tag, hd.tgt, 2'b10};
      end else begin
        h = int'(cur[1:0]);
        h = hd.taken ? ((h == 3) ? 3 : h + 1) : ((h == 0) ? 0 : h - 1);
        e_wr = 1;
        e_ent = {1'b1, hd.tag, cur[9:2], 2'(h)};
      end
    end
    check_eq("upd_ready", upd_ready, e_rdy);
    check_eq("inv_busy", inv_busy, m_sweep);
    check_eq("lookup_block", lookup_block, m_sweep);
    check_eq("q_count", q_count, mq.size());
    check_eq("wr_en", btb_wr_en, e_wr);
    if (e_wr) begin
      check_eq("wr_idx", btb_wr_idx, e_idx);
      check_eq("wr_entry", btb_wr_entry, e_ent);
    end
    if (!m_sweep && mq.size() > 0) check_eq("rd_idx", btb_rd_idx, mq[0].idx);
    o_rdy = upd_ready; o_busy = inv_busy; o_cnt = q_count;
    o_wr_en = btb_wr_en; o_wr_idx = btb_wr_idx; o_wr_ent = btb_wr_entry;
    if (e_wr) ref_btb[e_idx] = e_ent;
    if (rs) begin
      mq.delete(); m_sweep = 0; m_cnt = 0;
    end else if (m_sweep) begin
      if (!st) begin
        m_cnt++;
        if (m_cnt == 8) m_sweep = 0;
      end
    end else if (inv) begin
      mq.delete(); m_sweep = 1; m_cnt = 0;
    end else begin
      if (!st && mq.size() > 0) void'(mq.pop_front());
      if (v && e_rdy) begin
        nu.idx = pc[4:2]; nu.tag = pc[7:5]; nu.taken = tk; nu.tgt = tg[7:0];
        mq.push_back(nu);
      end
    end
  endtask

  task automatic idle(input bit st);
    step(0, 32'h0, 0, 32'h0, 0, st, 0);
  endtask

  initial begin
    int busy_cycles;
    int exp_hist [4];
    logic [31:0] rpc, rtg;
    exp_hist[0] = 2; exp_hist[1] = 1; exp_hist[2] = 0; exp_hist[3] = 0;
    m_sweep = 0; m_cnt = 0;
    for (int i = 0; i < 8; i++) ref_btb[i] = '0;
    rst = 1; memory_stall = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; inv_req = 0;
    repeat (2) @(posedge clk);

    // Reset state, then three queued updates flushed by a sweep with one stall
    idle(0);
    check_eq("rst_q_count", o_cnt, 0);
    check_eq("rst_ready", o_rdy, 1);
    check_eq("rst_wr_en", o_wr_en, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h100 + 32'(i * 4), 1, 32'h11, 0, 1, 0);
    step(0, 32'h0, 0, 32'h0, 1, 0, 0);
    busy_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      idle(i == 3);
      if (o_busy) busy_cycles++;
    end
    check_eq("sweep_len", busy_cycles, 9);
    idle(0);
    check_eq("sweep_done", o_busy, 0);
    check_eq("sweep_flush", o_cnt, 0);

    // Allocate
    step(1, 32'h48, 1, 32'h9C, 0, 0, 0);
    idle(0);
    check_eq("alloc_en", o_wr_en, 1);
    check_eq("alloc_idx", o_wr_idx, 2);
    check_eq("alloc_entry", o_wr_ent, {1'b1, 3'b010, 8'h9C, 2'b10});
    idle(0);
    check_eq("alloc_drain", o_cnt, 0);

    // Saturate up, then step history down to zero and hold there
    step(1, 32'h48, 1, 32'h9C, 0, 0, 0);
    idle(0);
    check_eq("hist_up", o_wr_ent[1:0], 3);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h48, 0, 32'h9C, 0, 0, 0);
      idle(0);
      check_eq("hist_down", o_wr_ent[1:0], exp_hist[i]);
    end

    // Retarget
    step(1, 32'h48, 1, 32'h55, 0, 0, 0);
    idle(0);
    check_eq("retarget", o_wr_ent, {1'b1, 3'b010, 8'h55, 2'b10});

    // Fill while stalled, fifth push refused, then drain back-to-back
    for (int i = 0; i < 5; i++) step(1, 32'h10 + 32'(i * 20), 1, 32'h30 + 32'(i), 0, 1, 0);
    check_eq("full_count", o_cnt, 4);
    check_eq("full_ready", o_rdy, 0);
    for (int i = 0; i < 4; i++) begin
      idle(0);
      check_eq("drain_wr", o_wr_en, 1);
    end
    idle(0);

    // inv_req beats a simultaneous push; reset aborts a running sweep
    step(1, 32'h48, 1, 32'h77, 1, 0, 0);
    check_eq("prio_ready", o_rdy, 0);
    repeat (3) idle(0);
    step(0, 32'h0, 0, 32'h0, 0, 0, 1);
    idle(0);
    check_eq("rst_abort", o_busy, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom & 32'h0000_00FC;
      rtg = 32'h40 + 32'($urandom_range(0, 3));
      step(($urandom_range(0, 9) < 7), rpc | ($urandom & 32'hFFFF_FF00), $urandom_range(0, 1),
           rtg, ($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 399) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
